// File: rtl/alu_sequencer_pkg.sv
// Shared opcode/state encodings and helpers for the ALU sequencer slice.
package alu_sequencer_pkg;

    localparam int NUM_UNITS = 4;
    localparam int RES_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_SUMA  = 2'b00,
        OP_RESTA = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_WAIT   = 2'b10,
        S_DONE   = 2'b11
    } state_e;

    function automatic logic [NUM_UNITS-1:0] op_onehot(input op_e op);
        return NUM_UNITS'(1) << op;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and the four arithmetic units.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int OPW = 3
);
    logic [OPW-1:0]       op_a;
    logic [OPW-1:0]       op_b;
    logic [NUM_UNITS-1:0] init;
    logic [NUM_UNITS-1:0] done;
    logic [3:0]           res_sum;
    logic [3:0]           res_resta;
    logic [2*OPW-1:0]     res_mult;
    logic [3:0]           res_div;

    modport master (
        output op_a, op_b, init,
        input  done, res_sum, res_resta, res_mult, res_div
    );

    modport slave (
        input  op_a, op_b, init,
        output done, res_sum, res_resta, res_mult, res_div
    );
endinterface

// File: rtl/alu_sequencer_edge_rise.sv
// Registered rising-edge detector; pulse is high in the cycle the input first reads high.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);
    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d_i;
    end

    assign pulse_o = d_i & ~d_q;
endmodule

// File: rtl/alu_sequencer.sv
// Control FSM for the ALU datapath: latch operands, pulse one unit's init,
// wait for its done (or time out), then hold the captured result.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int             OPW       = 3,
    parameter int             RES_W     = RES_W_DEF,
    parameter int             TIMEOUT   = 64,
    parameter logic [NUM_UNITS-1:0] COMB_MASK = 4'b0011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       opcode_i,
    input  logic [OPW-1:0]   a_in_i,
    input  logic [OPW-1:0]   b_in_i,
    alu_sequencer_if.master  unit,
    output logic [RES_W-1:0] result_o,
    output logic             result_valid_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e           state_q, state_d;
    op_e              op_sel_q, op_sel_d;
    logic [OPW-1:0]   op_a_q, op_a_d;
    logic [OPW-1:0]   op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             start_pulse;
    logic             complete;
    logic [RES_W-1:0] sel_res;

    edge_rise u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .d_i     (start_i),
        .pulse_o (start_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_sel_q <= OP_SUMA;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_sel_q <= op_sel_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Narrower unit results are zero-extended into the held result register.
    always_comb begin
        sel_res = '0;
        unique case (op_sel_q)
            OP_SUMA:  sel_res = RES_W'(unit.res_sum);
            OP_RESTA: sel_res = RES_W'(unit.res_resta);
            OP_MULT:  sel_res = RES_W'(unit.res_mult);
            OP_DIV:   sel_res = RES_W'(unit.res_div);
            default:  sel_res = '0;
        endcase
    end

    assign complete = unit.done[op_sel_q] | COMB_MASK[op_sel_q];

    always_comb begin
        state_d   = state_q;
        op_sel_d  = op_sel_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = valid_q;
        err_d     = err_q;
        unit.init = '0;
        busy_o    = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_pulse) begin
                    op_sel_d = op_e'(opcode_i);
                    op_a_d   = a_in_i;
                    op_b_d   = b_in_i;
                    valid_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                unit.init = op_onehot(op_sel_q);
                busy_o    = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                busy_o = 1'b1;
                // A completing unit beats a timeout landing on the same cycle.
                if (complete) begin
                    result_d = sel_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    valid_d  = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign unit.op_a      = op_a_q;
    assign unit.op_b      = op_b_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: two instances (long and short timeout) share
// one stimulus stream and are compared against an outcome model per operation.
module tb_alu_sequencer;
    localparam int TMO0 = 64;
    localparam int TMO1 = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] opcode = 2'd0;
    logic [2:0] a_in = 3'd0;
    logic [2:0] b_in = 3'd0;
    logic [3:0] done_drv = 4'd0;

    int n_chk = 0;
    int n_bad = 0;
    int prev_res [2];

    logic [5:0] res_w   [2];
    logic       valid_w [2];
    logic       busy_w  [2];
    logic       err_w   [2];
    logic [3:0] init_w  [2];
    logic [2:0] opa_w   [2];
    logic [2:0] opb_w   [2];

    always #5 clk = ~clk;

    alu_sequencer_if #(.OPW(3)) u0 ();
    alu_sequencer_if #(.OPW(3)) u1 ();

    // Behavioural arithmetic units answering each sequencer's latched operands.
    assign u0.done      = done_drv;
    assign u0.res_sum   = 4'(u0.op_a) + 4'(u0.op_b);
    assign u0.res_resta = 4'(u0.op_a) - 4'(u0.op_b);
    assign u0.res_mult  = 6'(u0.op_a) * 6'(u0.op_b);
    assign u0.res_div   = (u0.op_b == 3'd0) ? 4'hF : 4'(u0.op_a) / 4'(u0.op_b);
    assign u1.done      = done_drv;
    assign u1.res_sum   = 4'(u1.op_a) + 4'(u1.op_b);
    assign u1.res_resta = 4'(u1.op_a) - 4'(u1.op_b);
    assign u1.res_mult  = 6'(u1.op_a) * 6'(u1.op_b);
    assign u1.res_div   = (u1.op_b == 3'd0) ? 4'hF : 4'(u1.op_a) / 4'(u1.op_b);

    assign init_w[0] = u0.init;
    assign init_w[1] = u1.init;
    assign opa_w[0]  = u0.op_a;
    assign opa_w[1]  = u1.op_a;
    assign opb_w[0]  = u0.op_b;
    assign opb_w[1]  = u1.op_b;

    alu_sequencer #(.TIMEOUT(TMO0)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .opcode_i       (opcode),
        .a_in_i         (a_in),
        .b_in_i         (b_in),
        .unit           (u0),
        .result_o       (res_w[0]),
        .result_valid_o (valid_w[0]),
        .busy_o         (busy_w[0]),
        .err_o          (err_w[0])
    );

    alu_sequencer #(.TIMEOUT(TMO1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .opcode_i       (opcode),
        .a_in_i         (a_in),
        .b_in_i         (b_in),
        .unit           (u1),
        .result_o       (res_w[1]),
        .result_valid_o (valid_w[1]),
        .busy_o         (busy_w[1]),
        .err_o          (err_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_res(input int op, input int a, input int b);
        case (op)
            0: return a + b;
            1: return (a - b + 16) % 16;
            2: return a * b;
            default: return (b == 0) ? 15 : a / b;
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_init", tag, d), init_w[d], 0);
            chk($sformatf("%s_d%0d_busy", tag, d), busy_w[d], 0);
            chk($sformatf("%s_d%0d_valid", tag, d), valid_w[d], 0);
            chk($sformatf("%s_d%0d_err", tag, d), err_w[d], 0);
            chk($sformatf("%s_d%0d_res", tag, d), res_w[d], 0);
            chk($sformatf("%s_d%0d_opa", tag, d), opa_w[d], 0);
        end
    endtask

    // k: cycles from init to a one-cycle done pulse on the selected unit (0 = never).
    // held: selected done already high before start. inj: extra start edge mid-wait.
    task automatic run_op(input int op, input int a, input int b, input int k,
                          input bit held, input bit inj, input int hold);
        int fin_exp [2];
        int fin_obs [2];
        int busy_n  [2];
        int init_n  [2];
        int rexp    [2];
        int eexp    [2];
        int tmo, minfin, maxfin, last, e, h;
        logic [3:0] sel;
        sel = 4'(1 << op);
        h = inj ? 1 : hold;
        for (int d = 0; d < 2; d++) begin
            tmo = (d == 0) ? TMO0 : TMO1;
            if (op < 2 || held)          fin_exp[d] = 3;
            else if (k >= 1 && k <= tmo) fin_exp[d] = k + 2;
            else                         fin_exp[d] = tmo + 2;
            eexp[d]    = (op >= 2 && !held && !(k >= 1 && k <= tmo)) ? 1 : 0;
            rexp[d]    = eexp[d] ? 0 : ref_res(op, a, b);
            fin_obs[d] = 0;
            busy_n[d]  = 0;
            init_n[d]  = 0;
        end
        minfin = (fin_exp[0] < fin_exp[1]) ? fin_exp[0] : fin_exp[1];
        maxfin = (fin_exp[0] > fin_exp[1]) ? fin_exp[0] : fin_exp[1];
        last = maxfin;
        if (h > last) last = h;
        if (k + 2 > last) last = k + 2;
        last = last + 3;
        e = inj ? $urandom_range(minfin - 1, 2) : 0;

        @(negedge clk);
        opcode = 2'(op);
        a_in   = 3'(a);
        b_in   = 3'(b);
        start  = 1'b1;
        if (held) done_drv = sel;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (c == 1) begin
                    chk($sformatf("op%0d_d%0d_init1", op, d), init_w[d], sel);
                    chk($sformatf("op%0d_d%0d_opa", op, d), opa_w[d], a);
                    chk($sformatf("op%0d_d%0d_opb", op, d), opb_w[d], b);
                    chk($sformatf("op%0d_d%0d_vclr", op, d), {valid_w[d], err_w[d]}, 0);
                    chk($sformatf("op%0d_d%0d_reskeep", op, d), res_w[d], prev_res[d]);
                end
                if (init_w[d] != 4'd0) init_n[d]++;
                if (busy_w[d]) busy_n[d]++;
                if (!busy_w[d] && fin_obs[d] == 0) begin
                    fin_obs[d] = c;
                    chk($sformatf("op%0d_d%0d_res", op, d), res_w[d], rexp[d]);
                    chk($sformatf("op%0d_d%0d_valid", op, d), valid_w[d], 1 - eexp[d]);
                    chk($sformatf("op%0d_d%0d_err", op, d), err_w[d], eexp[d]);
                end
                if (c == last)
                    chk($sformatf("op%0d_d%0d_held", op, d),
                        {res_w[d], valid_w[d], err_w[d]}, {6'(rexp[d]), 1'(1 - eexp[d]), 1'(eexp[d])});
            end
            if (c == 1) begin
                opcode = 2'($urandom);
                a_in   = 3'($urandom);
                b_in   = 3'($urandom);
            end
            if (c == h) start = 1'b0;
            if (inj && c == e) start = 1'b1;
            if (inj && c == e + 1) start = 1'b0;
            done_drv = (done_drv & sel) | (4'($urandom) & ~sel);
            if (!held && k > 0 && c == k + 1) done_drv = done_drv | sel;
            if (!held && k > 0 && c == k + 2) done_drv = done_drv & ~sel;
            if (c >= last - 1) done_drv = 4'd0;
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("op%0d_d%0d_lat", op, d), fin_obs[d], fin_exp[d]);
            chk($sformatf("op%0d_d%0d_busyn", op, d), busy_n[d], fin_exp[d] - 1);
            chk($sformatf("op%0d_d%0d_initn", op, d), init_n[d], 1);
            prev_res[d] = rexp[d];
        end
    endtask

    task automatic rst_mid(input int at);
        @(negedge clk);
        opcode = 2'd2;
        a_in   = 3'($urandom);
        b_in   = 3'($urandom);
        start  = 1'b1;
        for (int c = 1; c <= at; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk_zero($sformatf("rstmid%0d", at));
        @(negedge clk);
        rst = 1'b0;
        prev_res[0] = 0;
        prev_res[1] = 0;
    endtask

    initial begin
        prev_res[0] = 0;
        prev_res[1] = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        run_op(0, 3, 5, 0, 1'b0, 1'b0, 1);
        run_op(2, 7, 7, 10, 1'b0, 1'b0, 1);
        run_op(3, 5, 2, 0, 1'b0, 1'b0, 1);
        run_op(2, 6, 5, 12, 1'b0, 1'b1, 1);
        run_op(3, 6, 3, TMO1, 1'b0, 1'b0, 2);
        run_op(3, 7, 2, TMO1 + 1, 1'b0, 1'b0, 1);
        run_op(2, 5, 3, TMO0, 1'b0, 1'b0, 1);
        run_op(2, 4, 4, TMO0 + 1, 1'b0, 1'b0, 1);
        run_op(2, 3, 3, 0, 1'b1, 1'b0, 2);
        run_op(1, 2, 6, 0, 1'b0, 1'b0, 20);

        for (int i = 0; i < 40; i++) begin
            int op, k;
            op = $urandom_range(0, 3);
            k  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
            run_op(op, $urandom_range(0, 7), $urandom_range(0, 7), k,
                   ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
        end

        rst_mid(1);
        run_op(0, 7, 6, 0, 1'b0, 1'b0, 1);
        rst_mid(3);
        run_op(2, 6, 6, 4, 1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
